// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit per clock out.
// Optional even-parity trailer bit per frame when SER_PARITY_EN is defined.
module bit_serializer #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             dout,
   output logic             dout_valid,
   output logic             word_start,
   output logic             busy
);

`ifdef SER_PARITY_EN
   localparam int FL = WIDTH + 1;
`else
   localparam int FL = WIDTH;
`endif
   localparam int CW = $clog2(FL);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             accept;
   logic             last;
   logic             data_bit;

   assign last     = (state_q == SHIFT) && (cnt_q == CW'(FL - 1));
   assign in_ready = (state_q == IDLE) || last;
   assign accept   = in_valid && in_ready;

`ifdef SER_PARITY_EN
   logic par_q, par_d;

   always_comb begin
      par_d = par_q;
      if (accept) par_d = ^in_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) par_q <= 1'b0;
      else     par_q <= par_d;
   end
`endif

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      if (accept) begin
         shreg_d = in_data;
         cnt_d   = '0;
         state_d = SHIFT;
      end else if (state_q == SHIFT) begin
         if (last) begin
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
         end else begin
            if (MSB_FIRST != 0) shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            else                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs decode straight from the flops, so reset clears them at once.
   always_comb begin
      data_bit = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
`ifdef SER_PARITY_EN
      if (cnt_q == CW'(WIDTH)) data_bit = par_q;
`endif
   end

   assign busy       = (state_q == SHIFT);
   assign dout_valid = busy;
   assign dout       = busy && data_bit;
   assign word_start = busy && (cnt_q == '0);

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: MSB-first and LSB-first instances share inputs.
// Expected bit streams are computed from the words; parity bit included under SER_PARITY_EN.
module tb_bit_serializer;

`ifdef SER_PARITY_EN
   localparam int FL = 9;
`else
   localparam int FL = 8;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready, dout, dout_valid, word_start, busy;
   logic       l_ready, l_dout, l_valid, l_start, l_busy;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .dout(dout), .dout_valid(dout_valid),
      .word_start(word_start), .busy(busy)
   );

   bit_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_l (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(l_ready), .dout(l_dout), .dout_valid(l_valid),
      .word_start(l_start), .busy(l_busy)
   );

   function automatic logic eb(input logic [7:0] w, input int i, input bit msb);
      if (i >= 8) return ^w;
      return msb ? w[7-i] : w[i];
   endfunction

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_dv"}, dout_valid, 1'b0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_dout"}, dout, 1'b0);
      chk({tag, "_ws"}, word_start, 1'b0);
      chk({tag, "_rdy"}, in_ready, 1'b1);
   endtask

   logic [7:0] w;

   initial begin
      rst = 1'b1;
      in_data = 8'h00;
      in_valid = 1'b0;
      step();
      step();
      chk_idle("rst");
      chk("rst_l_dv", l_valid, 1'b0);
      rst = 1'b0;
      step();
      chk_idle("post_rst");

      // single word, data changed mid-frame, then idle
      in_data = 8'h71;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      in_data = 8'hFF;
      for (int i = 0; i < FL; i++) begin
         chk($sformatf("w71_m_b%0d", i), dout, eb(8'h71, i, 1'b1));
         chk($sformatf("w71_l_b%0d", i), l_dout, eb(8'h71, i, 1'b0));
         chk($sformatf("w71_dv%0d", i), dout_valid, 1'b1);
         chk($sformatf("w71_ws%0d", i), word_start, i == 0);
         chk($sformatf("w71_l_ws%0d", i), l_start, i == 0);
         chk($sformatf("w71_rdy%0d", i), in_ready, i == FL - 1);
         chk($sformatf("w71_busy%0d", i), busy, 1'b1);
         step();
      end
      for (int i = 0; i < 3; i++) begin
         chk_idle($sformatf("idle%0d", i));
         chk($sformatf("idle_l_dout%0d", i), l_dout, 1'b0);
         step();
      end

      // back-to-back words with in_valid held
      in_data = 8'h71;
      in_valid = 1'b1;
      step();
      in_data = `ifdef SER_PARITY_EN 8'h70 `else 8'hE2 `endif;
      for (int k = 0; k < 2 * FL; k++) begin
         w = (k < FL) ? 8'h71 : in_data;
         chk($sformatf("b2b_b%0d", k), dout, eb(w, k % FL, 1'b1));
         chk($sformatf("b2b_dv%0d", k), dout_valid, 1'b1);
         chk($sformatf("b2b_ws%0d", k), word_start, k == 0 || k == FL);
         chk($sformatf("b2b_rdy%0d", k), in_ready, k == FL - 1 || k == 2 * FL - 1);
         if (k == 2 * FL - 1) in_valid = 1'b0;
         step();
      end
      chk_idle("b2b_end");

      // reset asserted mid-frame
      in_data = 8'h71;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("pre_rst_b%0d", i), dout, eb(8'h71, i, 1'b1));
         step();
      end
      rst = 1'b1;
      #1;
      chk("async_dv", dout_valid, 1'b0);
      chk("async_busy", busy, 1'b0);
      chk("async_dout", dout, 1'b0);
      chk("async_rdy", in_ready, 1'b1);
      step();
      rst = 1'b0;
      in_data = 8'hE2;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < FL; i++) begin
         chk($sformatf("wE2_b%0d", i), dout, eb(8'hE2, i, 1'b1));
         chk($sformatf("wE2_ws%0d", i), word_start, i == 0);
         chk($sformatf("wE2_dv%0d", i), dout_valid, 1'b1);
         step();
      end
      chk_idle("wE2_end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
